// File: rtl/pbw_pkg.sv
// pbw_pkg: shared types and helpers for the packet burst writer.
//   pbw_state_e : control FSM states
//   be_mask()   : byteenable pattern for the final beat of a packet
package pbw_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SETUP = 3'd2,
    BURST = 3'd3,
    DONE  = 3'd4
  } pbw_state_e;

  // Widest byteenable the helper can build (DW up to 1024 bits).
  localparam int unsigned MAX_BE_W = 128;

  // Low (len mod bytes) lanes set; all lanes set when the packet ends on a
  // word boundary. Callers cast the result down to their own lane count.
  function automatic logic [MAX_BE_W-1:0] be_mask(input int unsigned len,
                                                  input int unsigned bytes);
    int unsigned rem;
    rem = len % bytes;
    if (rem == 32'd0) begin
      be_mask = {MAX_BE_W{1'b1}};
    end else begin
      be_mask = (MAX_BE_W'(1'b1) << rem) - MAX_BE_W'(1'b1);
    end
  endfunction

endpackage

// File: rtl/pbw_prefetch.sv
// pbw_prefetch: 2-entry valid/ready skid buffer between the FIFO read port
// and the Avalon write-data register.
//   clk, reset            : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data    : upstream (FIFO read data) side
//   out_valid/out_ready/out_data : downstream (write-data stage) side
//   count                 : current occupancy, used for read-ahead accounting
module pbw_prefetch
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    count
);

  logic [DW-1:0] mem_r [2];
  logic          wr_idx_r;
  logic          rd_idx_r;
  logic [1:0]    count_r;
  logic          push_s;
  logic          pop_s;

  assign in_ready  = (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign out_data  = mem_r[rd_idx_r];
  assign count     = count_r;
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  // Entry storage and read/write pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_r[0] <= {DW{1'b0}};
      mem_r[1] <= {DW{1'b0}};
      wr_idx_r <= 1'b0;
      rd_idx_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_idx_r] <= in_data;
        wr_idx_r        <= ~wr_idx_r;
      end
      if (pop_s) begin
        rd_idx_r <= ~rd_idx_r;
      end
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pkt_burst_writer.sv
// pkt_burst_writer: drains one packet from the capture FIFO and writes it
// into a circular host-memory ring with Avalon-MM bursts, split at MAX_BURST
// beats and at the ring end.
//   clk, reset              : clock, asynchronous active-low reset
//   start, pkt_begin/end    : packet request (byte offsets, end exclusive)
//   ring_base/size, wr_ptr  : ring geometry and destination address
//   busy, done, err         : status; next_wr_ptr valid with done
//   fifo_rdata/empty/rd     : capture FIFO read port (1-cycle read latency)
//   avm_*                   : Avalon-MM burst write master
module pkt_burst_writer
  import pbw_pkg::*;
#(
  parameter  int DW        = 32,
  parameter  int AW        = 32,
  parameter  int MAX_BURST = 16,
  parameter  int LENW      = 16,
  localparam int BYTES     = DW / 8,
  localparam int BCW       = $clog2(MAX_BURST) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LENW-1:0]  pkt_begin,
  input  logic [LENW-1:0]  pkt_end,
  input  logic [AW-1:0]    ring_base,
  input  logic [AW-1:0]    ring_size,
  input  logic [AW-1:0]    wr_ptr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AW-1:0]    next_wr_ptr,
  input  logic [DW-1:0]    fifo_rdata,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic [AW-1:0]    avm_address,
  output logic [DW-1:0]    avm_writedata,
  output logic [BYTES-1:0] avm_byteenable,
  output logic             avm_write,
  output logic [BCW-1:0]   avm_burstcount,
  input  logic             avm_waitrequest
);

  localparam int LOG2B = $clog2(BYTES);
  localparam int BW    = LENW + 1;                 // beat counters
  localparam int MW    = (AW > BW) ? AW : BW;      // burst-minimum compare width

  pbw_state_e state_r, state_s;

  logic [LENW-1:0]  len_r;
  logic             bad_r;
  logic [AW-1:0]    ring_base_r, ring_size_r, cur_addr_r;
  logic [BW-1:0]    beats_r, beats_left_r, reads_r, ld_total_r;
  logic [BYTES-1:0] be_last_r;
  logic [BCW-1:0]   burst_len_r, ld_cnt_r, acc_cnt_r;

  logic             busy_r, done_r, err_r, fifo_rd_r, dv_r;
  logic [AW-1:0]    next_wr_ptr_r, avm_address_r;
  logic [DW-1:0]    avm_writedata_r;
  logic [BYTES-1:0] avm_byteenable_r;
  logic             avm_write_r;
  logic [BCW-1:0]   avm_burstcount_r;

  logic             err_s, accept_s, last_acc_s, load_s, last_load_s, rd_ok_s;
  logic [AW-1:0]    dist_s, dist_beats_s, step_s;
  logic [MW-1:0]    min_a_s, min_b_s;
  logic [BCW-1:0]   burst_s;
  logic [BW-1:0]    beats_calc_s;

  logic             pf_in_ready, pf_out_valid;
  logic [DW-1:0]    pf_out_data;
  logic [1:0]       pf_count;

  pbw_prefetch #(.DW(DW)) u_prefetch (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (dv_r),
    .in_ready  (pf_in_ready),
    .in_data   (fifo_rdata),
    .out_valid (pf_out_valid),
    .out_ready (load_s),
    .out_data  (pf_out_data),
    .count     (pf_count)
  );

  assign busy           = busy_r;
  assign done           = done_r;
  assign err            = err_r;
  assign next_wr_ptr    = next_wr_ptr_r;
  assign fifo_rd        = fifo_rd_r;
  assign avm_address    = avm_address_r;
  assign avm_writedata  = avm_writedata_r;
  assign avm_byteenable = avm_byteenable_r;
  assign avm_write      = avm_write_r;
  assign avm_burstcount = avm_burstcount_r;

  assign beats_calc_s = (BW'(len_r) + BW'(BYTES - 1)) >> LOG2B;
  assign accept_s     = avm_write_r && !avm_waitrequest;
  assign last_acc_s   = (state_r == BURST) && accept_s &&
                        (acc_cnt_r == burst_len_r - BCW'(1));
  // Refill the write-data register when it is empty or draining this cycle.
  assign load_s       = (state_r == BURST) && pf_out_valid &&
                        (ld_cnt_r != burst_len_r) && (!avm_write_r || accept_s);
  assign last_load_s  = (ld_total_r == beats_r - BW'(1));
  // fifo_rd is registered, so back-to-back reads are not issued: the empty
  // flag seen here must already reflect the previous read. Room counts the
  // entry in flight (dv_r) plus the one this read will bring.
  assign rd_ok_s      = ((state_r == SETUP) || (state_r == BURST)) &&
                        !fifo_empty && !fifo_rd_r && pf_in_ready &&
                        (reads_r != beats_r) &&
                        (({1'b0, pf_count} + {2'b00, dv_r}) < 3'd2);

  // Burst length = min(MAX_BURST, beats left, beats to ring end).
  always_comb begin
    dist_s       = ring_size_r - (cur_addr_r - ring_base_r);
    dist_beats_s = dist_s >> LOG2B;
    min_a_s      = (MW'(beats_left_r) < MW'(MAX_BURST)) ? MW'(beats_left_r)
                                                        : MW'(MAX_BURST);
    min_b_s      = (MW'(dist_beats_s) < min_a_s) ? MW'(dist_beats_s) : min_a_s;
    burst_s      = BCW'(min_b_s);
    step_s       = AW'(burst_s) << LOG2B;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state and error strobe.
  always_comb begin
    state_s = state_r;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) state_s = CHECK;
        else       state_s = IDLE;
      end
      CHECK: begin
        if (bad_r) begin
          state_s = IDLE;
          err_s   = 1'b1;
        end else if (len_r == {LENW{1'b0}}) begin
          state_s = DONE;
        end else begin
          state_s = SETUP;
        end
      end
      SETUP: state_s = BURST;
      BURST: begin
        if (last_acc_s) begin
          if (beats_left_r != {BW{1'b0}}) state_s = SETUP;
          else                            state_s = DONE;
        end else begin
          state_s = BURST;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Packet and burst bookkeeping: request latch, beat counters, ring address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_r        <= {LENW{1'b0}};
      bad_r        <= 1'b0;
      ring_base_r  <= {AW{1'b0}};
      ring_size_r  <= {AW{1'b0}};
      cur_addr_r   <= {AW{1'b0}};
      beats_r      <= {BW{1'b0}};
      beats_left_r <= {BW{1'b0}};
      ld_total_r   <= {BW{1'b0}};
      be_last_r    <= {BYTES{1'b0}};
      burst_len_r  <= {BCW{1'b0}};
      ld_cnt_r     <= {BCW{1'b0}};
      acc_cnt_r    <= {BCW{1'b0}};
    end else if ((state_r == IDLE) && start) begin
      len_r       <= pkt_end - pkt_begin;
      bad_r       <= (pkt_end < pkt_begin);
      ring_base_r <= ring_base;
      ring_size_r <= ring_size;
      cur_addr_r  <= wr_ptr;
    end else if (state_r == CHECK) begin
      beats_r      <= beats_calc_s;
      beats_left_r <= beats_calc_s;
      ld_total_r   <= {BW{1'b0}};
      be_last_r    <= BYTES'(be_mask(32'(len_r), BYTES));
    end else if (state_r == SETUP) begin
      burst_len_r  <= burst_s;
      ld_cnt_r     <= {BCW{1'b0}};
      acc_cnt_r    <= {BCW{1'b0}};
      beats_left_r <= beats_left_r - BW'(burst_s);
      // A burst that reaches the ring end exactly wraps the pointer.
      cur_addr_r   <= (step_s == dist_s) ? ring_base_r : (cur_addr_r + step_s);
    end else if (state_r == BURST) begin
      if (load_s) begin
        ld_cnt_r   <= ld_cnt_r + BCW'(1);
        ld_total_r <= ld_total_r + BW'(1);
      end
      if (accept_s) begin
        acc_cnt_r <= acc_cnt_r + BCW'(1);
      end
    end
  end

  // FIFO read strobe, read-data valid tracking and per-packet read count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_rd_r <= 1'b0;
      dv_r      <= 1'b0;
      reads_r   <= {BW{1'b0}};
    end else begin
      fifo_rd_r <= rd_ok_s;
      dv_r      <= fifo_rd_r;
      if (state_r == IDLE) begin
        reads_r <= {BW{1'b0}};
      end else if (rd_ok_s) begin
        reads_r <= reads_r + BW'(1);
      end
    end
  end

  // Avalon master outputs; data/byteenable only change on load, so they hold
  // under waitrequest.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      avm_address_r    <= {AW{1'b0}};
      avm_burstcount_r <= {BCW{1'b0}};
      avm_write_r      <= 1'b0;
      avm_writedata_r  <= {DW{1'b0}};
      avm_byteenable_r <= {BYTES{1'b0}};
    end else begin
      if (state_r == SETUP) begin
        avm_address_r    <= cur_addr_r;
        avm_burstcount_r <= burst_s;
      end
      if (load_s) begin
        avm_write_r      <= 1'b1;
        avm_writedata_r  <= pf_out_data;
        avm_byteenable_r <= last_load_s ? be_last_r : {BYTES{1'b1}};
      end else if (accept_s) begin
        avm_write_r <= 1'b0;
      end
    end
  end

  // Status outputs, registered from the next state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      next_wr_ptr_r <= {AW{1'b0}};
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_s == DONE);
      err_r  <= err_s;
      if (state_s == DONE) begin
        next_wr_ptr_r <= cur_addr_r;
      end
    end
  end

endmodule

// File: tb/tb_pkt_burst_writer.sv
// tb_pkt_burst_writer: randomized self-checking bench for pkt_burst_writer.
// A queue-based FIFO and a random-stall Avalon slave surround the DUT; the
// expected burst list is derived from the ring/length arithmetic directly.
module tb_pkt_burst_writer;

  localparam int DW = 32, AW = 32, MAX_BURST = 16, LENW = 16;
  localparam int BYTES = DW / 8;
  localparam int BCW = $clog2(MAX_BURST) + 1;

  logic clk = 1'b0;
  logic reset, start, busy, done, err, fifo_empty, fifo_rd, avm_write, avm_waitrequest;
  logic [LENW-1:0] pkt_begin, pkt_end;
  logic [AW-1:0] ring_base, ring_size, wr_ptr, next_wr_ptr, avm_address;
  logic [DW-1:0] fifo_rdata, avm_writedata;
  logic [BYTES-1:0] avm_byteenable;
  logic [BCW-1:0] avm_burstcount;

  always #5 clk = ~clk;

  pkt_burst_writer #(.DW(DW), .AW(AW), .MAX_BURST(MAX_BURST), .LENW(LENW)) dut (
    .clk(clk), .reset(reset), .start(start), .pkt_begin(pkt_begin), .pkt_end(pkt_end),
    .ring_base(ring_base), .ring_size(ring_size), .wr_ptr(wr_ptr), .busy(busy),
    .done(done), .err(err), .next_wr_ptr(next_wr_ptr), .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .avm_address(avm_address),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable), .avm_write(avm_write),
    .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest)
  );

  int n_cmp = 0, n_bad = 0;
  string cur_name = "init";

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0h, expected %0h", cur_name, tag, got, exp);
    end
  endtask

  // Environment state
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_data[$];
  int fifo_push_left = 0, fifo_pct = 100, stall_pct = 0;
  // Observations
  logic [AW-1:0] rec_addr[$];
  int rec_bc[$];
  logic [DW-1:0] rec_data[$];
  logic [BYTES-1:0] rec_be[$];
  int rd_cnt, done_cnt, err_cnt, write_cyc;
  logic [AW-1:0] ptr_seen;
  bit stalled_prev = 1'b0;
  logic [DW-1:0] snap_data;
  logic [BYTES-1:0] snap_be;
  logic [AW-1:0] snap_addr;
  logic [BCW-1:0] snap_bc;
  // Model results
  longint eb_addr[$];
  int eb_cnt[$];
  longint m_len, m_beats, m_next;
  bit m_err;
  logic [BYTES-1:0] m_last_be;

  // One clock: observe at the falling edge, drive just after the rising edge.
  task automatic cycle();
    bit rd_now;
    logic [DW-1:0] w;
    @(negedge clk);
    if (stalled_prev) begin
      check_eq("hold_write", avm_write, 1'b1);
      check_eq("hold_data", avm_writedata, snap_data);
      check_eq("hold_be", avm_byteenable, snap_be);
      check_eq("hold_addr", avm_address, snap_addr);
      check_eq("hold_bc", avm_burstcount, snap_bc);
    end
    stalled_prev = avm_write && avm_waitrequest;
    snap_data = avm_writedata; snap_be = avm_byteenable;
    snap_addr = avm_address;   snap_bc = avm_burstcount;
    if (avm_write) write_cyc++;
    if (avm_write && !avm_waitrequest) begin
      rec_addr.push_back(avm_address);
      rec_bc.push_back(int'(avm_burstcount));
      rec_data.push_back(avm_writedata);
      rec_be.push_back(avm_byteenable);
    end
    rd_now = fifo_rd;
    if (fifo_rd) begin
      rd_cnt++;
      check_eq("rd_nonempty", fifo_empty, 1'b0);
    end
    if (done) begin done_cnt++; ptr_seen = next_wr_ptr; end
    if (err) err_cnt++;
    @(posedge clk);
    #1;
    if (rd_now && fifo_q.size() > 0) fifo_rdata = fifo_q.pop_front();
    else fifo_rdata = $urandom;
    if (fifo_push_left > 0 && $urandom_range(99) < fifo_pct) begin
      w = $urandom;
      fifo_q.push_back(w);
      exp_data.push_back(w);
      fifo_push_left--;
    end
    fifo_empty = (fifo_q.size() == 0);
    avm_waitrequest = ($urandom_range(99) < stall_pct);
  endtask

  // Reference model plus environment setup for one packet.
  task automatic prep_pkt(input int pb, input int pe, input longint base, input longint size,
                          input longint wr, input int stl, input int fpct, input bit prefill);
    longint cur, left, b, room;
    logic [DW-1:0] w;
    int rem;
    eb_addr.delete(); eb_cnt.delete();
    m_err = (pe < pb);
    m_len = m_err ? 0 : (pe - pb);
    m_beats = (m_len + BYTES - 1) / BYTES;
    rem = int'(m_len % BYTES);
    m_last_be = (rem == 0) ? {BYTES{1'b1}} : BYTES'((1 << rem) - 1);
    cur = wr; left = m_beats;
    while (left > 0) begin
      room = (base + size - cur) / BYTES;
      b = MAX_BURST;
      if (left < b) b = left;
      if (room < b) b = room;
      eb_addr.push_back(cur); eb_cnt.push_back(int'(b));
      cur = cur + b * BYTES;
      if (cur == base + size) cur = base;
      left = left - b;
    end
    m_next = cur;
    fifo_q.delete(); exp_data.delete();
    rec_addr.delete(); rec_bc.delete(); rec_data.delete(); rec_be.delete();
    rd_cnt = 0; done_cnt = 0; err_cnt = 0; write_cyc = 0;
    fifo_push_left = int'(m_beats);
    if (m_beats == 0) begin
      // words present in the FIFO that must not be read
      w = $urandom; fifo_q.push_back(w);
      w = $urandom; fifo_q.push_back(w);
    end
    while (prefill && fifo_push_left > 0) begin
      w = $urandom; fifo_q.push_back(w); exp_data.push_back(w); fifo_push_left--;
    end
    fifo_empty = (fifo_q.size() == 0);
    stall_pct = stl; fifo_pct = fpct;
    pkt_begin = LENW'(pb); pkt_end = LENW'(pe);
    ring_base = AW'(base); ring_size = AW'(size); wr_ptr = AW'(wr);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check_eq("busy_start", busy, 1'b1);
  endtask

  // Wait for done/err; optionally fire ignored starts with junk inputs while busy.
  task automatic wait_end(input bit spur);
    for (int c = 0; c < 4000 && (done_cnt + err_cnt) == 0; c++) begin
      if (spur && busy && $urandom_range(3) == 0) begin
        start = 1'b1; pkt_begin = $urandom; pkt_end = $urandom; wr_ptr = $urandom;
      end
      cycle();
      start = 1'b0;
    end
    if ((done_cnt + err_cnt) == 0) check_eq("timeout", done_cnt + err_cnt, 1);
    repeat (6) cycle();
  endtask

  task automatic check_pkt();
    int idx;
    check_eq("busy_end", busy, 1'b0);
    check_eq("err_cnt", err_cnt, m_err ? 1 : 0);
    check_eq("done_cnt", done_cnt, m_err ? 0 : 1);
    check_eq("rd_cnt", rd_cnt, m_beats);
    check_eq("beat_cnt", rec_data.size(), m_beats);
    if (m_err || m_beats == 0) check_eq("write_cyc", write_cyc, 0);
    if (!m_err) check_eq("next_ptr", ptr_seen, m_next);
    idx = 0;
    for (int k = 0; k < eb_cnt.size(); k++) begin
      for (int j = 0; j < eb_cnt[k]; j++) begin
        if (idx < rec_data.size() && idx < exp_data.size()) begin
          check_eq("beat_addr", rec_addr[idx], eb_addr[k]);
          check_eq("beat_bc", rec_bc[idx], eb_cnt[k]);
          check_eq("beat_data", rec_data[idx], exp_data[idx]);
          check_eq("beat_be", rec_be[idx], (idx == m_beats - 1) ? m_last_be : {BYTES{1'b1}});
        end
        idx++;
      end
    end
  endtask

  task automatic run_pkt(input string name, input int pb, input int pe, input longint base,
                         input longint size, input longint wr, input int stl, input int fpct,
                         input bit prefill, input bit spur);
    cur_name = name;
    prep_pkt(pb, pe, base, size, wr, stl, fpct, prefill);
    wait_end(spur);
    check_pkt();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_write"}, avm_write, 1'b0);
    check_eq({tag, "_addr"}, avm_address, 0);
    check_eq({tag, "_bc"}, avm_burstcount, 0);
    check_eq({tag, "_data"}, avm_writedata, 0);
    check_eq({tag, "_be"}, avm_byteenable, 0);
    check_eq({tag, "_rd"}, fifo_rd, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_done"}, done, 1'b0);
    check_eq({tag, "_err"}, err, 1'b0);
    check_eq({tag, "_ptr"}, next_wr_ptr, 0);
  endtask

  initial begin
    longint base, size, wr;
    int pb, len, pe;
    reset = 1'b0; start = 1'b0; fifo_empty = 1'b1; fifo_rdata = '0; avm_waitrequest = 1'b0;
    pkt_begin = '0; pkt_end = '0; ring_base = '0; ring_size = '0; wr_ptr = '0;
    repeat (3) cycle();
    cur_name = "reset";
    check_all_zero("rst");
    reset = 1'b1;
    repeat (2) cycle();

    // Directed cases
    run_pkt("len100", 0, 100, 64'h1000, 64'h1000, 64'h1000, 0, 100, 1'b1, 1'b0);
    run_pkt("len70", 0, 70, 64'h1000, 64'h1000, 64'h1000, 0, 100, 1'b1, 1'b0);
    run_pkt("wrap", 10, 74, 64'h1000, 64'h100, 64'h10F0, 0, 100, 1'b1, 1'b0);
    run_pkt("len0", 50, 50, 64'h1000, 64'h1000, 64'h1200, 0, 100, 1'b1, 1'b0);
    run_pkt("bad", 80, 20, 64'h1000, 64'h1000, 64'h1000, 0, 100, 1'b1, 1'b0);
    run_pkt("stall", 3, 250, 64'h4000, 64'h80, 64'h4070, 50, 30, 1'b0, 1'b1);

    // Randomized packets with stalls, a starving FIFO and ignored starts
    for (int i = 0; i < 14; i++) begin
      base = 64'(($urandom_range(1, 15)) * 32'h1000);
      size = 64'($urandom_range(1, 96) * 4);
      wr = base + 64'($urandom_range(0, int'(size / 4) - 1) * 4);
      pb = $urandom_range(1, 500);
      case ($urandom_range(7))
        0: len = 0;
        1: len = -int'($urandom_range(1, pb));
        default: len = $urandom_range(1, 300);
      endcase
      pe = pb + len;
      run_pkt("rand", pb, pe, base, size, wr, 50, $urandom_range(20, 90), 1'b0, 1'b1);
    end

    // Reset during the fifth beat of a 16-beat burst
    cur_name = "reset_mid";
    prep_pkt(0, 64, 64'h2000, 64'h1000, 64'h2000, 0, 100, 1'b1);
    for (int c = 0; c < 300 && rec_data.size() < 4; c++) cycle();
    if (rec_data.size() < 4) check_eq("reach_beat5", rec_data.size(), 4);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async");
    fifo_q.delete(); fifo_push_left = 0; fifo_empty = 1'b1; stalled_prev = 1'b0;
    repeat (2) cycle();
    check_eq("no_done_after_rst", done_cnt, 0);
    reset = 1'b1;
    repeat (2) cycle();
    run_pkt("after_rst", 7, 160, 64'h2000, 64'h1000, 64'h2FC0, 30, 60, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
